// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } state_t;

  // A fetch address is usable only if word aligned and the whole word fits in the ROM.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] last_addr);
    return (addr[1:0] == 2'b00) && (addr <= last_addr);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears, stall holds, otherwise capture.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc,
  input  logic [INST_W-1:0] inst,
  input  logic              valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid
);

  logic [ADDR_W-1:0] id_pc_reg;
  logic [INST_W-1:0] id_inst_reg;
  logic              id_valid_reg;

  // Pipeline register update; flush takes priority over stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
      id_valid_reg <= 1'b0;
    end else if (flush) begin
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
      id_valid_reg <= 1'b0;
    end else if (!stall) begin
      id_pc_reg    <= pc;
      id_inst_reg  <= inst;
      id_valid_reg <= valid;
    end
  end

  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;
  assign id_valid = id_valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, branch/flush redirect, fault
// detection and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int                ROM_BYTES = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic              fetch_err
);

  // Highest address at which a full word still lies inside the ROM.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_BYTES - 4);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [ADDR_W-1:0] pend_target_reg, pend_target_next;
  logic              err_reg, err_next;

  // State, PC, pending-branch and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC;
      pend_valid_reg  <= 1'b0;
      pend_target_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pend_valid_reg  <= pend_valid_next;
      pend_target_reg <= pend_target_next;
      err_reg         <= err_next;
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pend_valid_next  = pend_valid_reg;
    pend_target_next = pend_target_reg;
    err_next         = err_reg;
    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        if (flush) begin
          pc_next         = flush_pc;
          pend_valid_next = 1'b0;
        end else if (stall) begin
          // A branch resolved while stalled is remembered until the stall lifts.
          if (branch_valid) begin
            pend_valid_next  = 1'b1;
            pend_target_next = branch_target;
          end
        end else if (pend_valid_reg) begin
          pc_next         = pend_target_reg;
          pend_valid_next = 1'b0;
        end else if (branch_valid) begin
          pc_next = branch_target;
        end else begin
          pc_next = pc_reg + 32'd4;
        end
        if (!addr_legal(pc_next, LAST_ADDR)) begin
          state_next      = FAULT;
          err_next        = 1'b1;
          pend_valid_next = 1'b0;
        end
      end
      FAULT: begin
        // Only a flush leaves FAULT; an illegal vector keeps us here.
        pend_valid_next = 1'b0;
        if (flush) begin
          pc_next = flush_pc;
          if (addr_legal(flush_pc, LAST_ADDR)) begin
            state_next = FETCH;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rom_en    = (state_reg == FETCH);
  assign rom_addr  = pc_reg;
  assign fetch_err = err_reg;

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .pc       (pc_reg),
    .inst     (rom_inst),
    .valid    (rom_en),
    .id_pc    (id_pc),
    .id_inst  (id_inst),
    .id_valid (id_valid)
  );

endmodule
